bus_arbiter16: RTL and testbench

Round-robin arbiter and sequencer for the 16-source, 32-bit shared datapath bus built on the 16:1 mux. Up to 16 requesters contend for the bus. The block drives the mux select, issues a one-hot grant, and qualifies transfers with a valid/ready handshake toward the consumer. Bus tenure is bounded by a burst limit for fairness, and a one-cycle turnaround separates any two owners.

---
 rtl/bus_arbiter16_if.sv | 29 ++
 rtl/bus_arbiter16.sv | 116 +++++++++++
 tb/tb_bus_arbiter16.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter16_if.sv
// Bus bundle between the 16-source arbiter, its requesters and the consumer.
// master: the arbiter side (drives select, grant and handshake qualifiers).
// slave:  the requester/consumer side (drives requests and ready).
interface bus_arbiter16_if;
    logic [15:0] req;
    logic        bus_ready;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        bus_valid;
    logic        arb_busy;

    modport master (
        input  req,
        input  bus_ready,
        output sel,
        output gnt,
        output bus_valid,
        output arb_busy
    );

    modport slave (
        output req,
        output bus_ready,
        input  sel,
        input  gnt,
        input  bus_valid,
        input  arb_busy
    );
endinterface

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter/sequencer for the 16:1 shared 32-bit bus.
// Drives the mux select and a one-hot grant, bounds each tenure to MAX_BURST beats
// and inserts one idle turnaround cycle between owners.
// Optional feature macro: ARB_PRIORITY_EN (requester 0 wins every arbitration it
// takes part in, without moving the round-robin pointer).
module bus_arbiter16 #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_arbiter16_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    localparam logic [CNT_W-1:0] BurstLast = CNT_W'(MAX_BURST - 1);

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [15:0]      gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       last_owner_q, last_owner_d;

    logic             found;
    logic [3:0]       win;
    logic [3:0]       idx;
    logic             prio_grant;
    logic             beat;

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.bus_valid = |(gnt_q & bus.req);
    assign bus.arb_busy  = (state_q != StIdle);
    assign beat          = bus.bus_valid & bus.bus_ready;

    // Winner search: first set request after last_owner, wrapping; last_owner itself last.
    always_comb begin
        found      = 1'b0;
        win        = 4'd0;
        idx        = 4'd0;
        prio_grant = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = last_owner_q + 4'(i);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef ARB_PRIORITY_EN
        // Requester 0 overrides the pointer and leaves it untouched.
        if (bus.req[0]) begin
            found      = 1'b1;
            win        = 4'd0;
            prio_grant = 1'b1;
        end
`endif
    end

    // Next-state: arbitration in IDLE/TURN, beat counting and tenure end in OWN.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        case (state_q)
            StIdle, StTurn: begin
                gnt_d = '0;
                if (found) begin
                    state_d = StOwn;
                    sel_d   = win;
                    gnt_d   = 16'd1 << win;
                    cnt_d   = '0;
                    if (!prio_grant) begin
                        last_owner_d = win;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StOwn: begin
                if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // sel_q is the owner index for the whole tenure.
                if (!bus.req[sel_q] || (beat && (cnt_q == BurstLast))) begin
                    state_d = StTurn;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any tenure in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= 4'd0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            last_owner_q <= 4'hF;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter16.sv
// Self-checking bench for bus_arbiter16 (MAX_BURST = 4).
// Each expected tenure (owner, beats, gap before it) is queued when stimulus is
// applied; a negedge monitor rebuilds tenures from gnt and pops/compares them.
module tb_bus_arbiter16;

    typedef struct {
        int owner;
        int beats;   // -1: don't care
        int gap;     // -1: don't care
    } ten_t;

    logic clk;
    logic rst_n;
    bus_arbiter16_if bif ();

    bus_arbiter16 #(
        .MAX_BURST (4),
        .CNT_W     (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    ten_t sb[$];

    bit in_ten    = 1'b0;
    int cur_owner = 0;
    int cur_beats = 0;
    int cur_gap   = 0;
    int gap_cnt   = 1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_ten(input int owner, input int beats, input int gap);
        ten_t t;
        t.owner = owner;
        t.beats = beats;
        t.gap   = gap;
        sb.push_back(t);
    endtask

    function automatic int onehot_idx(input logic [15:0] v);
        int r = -1;
        for (int i = 0; i < 16; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    task automatic end_tenure(input bit cut);
        ten_t e;
        if (sb.size() == 0) begin
            check_eq("sb_underflow", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check_eq("owner", cur_owner, e.owner);
            if (e.beats >= 0 && !cut) check_eq("beats", cur_beats, e.beats);
            if (e.gap >= 0) check_eq("gap", cur_gap, e.gap);
        end
    endtask

    // Monitor: rebuild tenures from the grant bus, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (in_ten) end_tenure(1'b1);
                in_ten  = 1'b0;
                gap_cnt = 1000;
            end else if (bif.gnt != 16'd0) begin
                if (!in_ten) begin
                    in_ten    = 1'b1;
                    cur_owner = onehot_idx(bif.gnt);
                    cur_beats = 0;
                    cur_gap   = gap_cnt;
                    check_eq("gnt_onehot", $countones(bif.gnt), 1);
                    check_eq("sel_owner", bif.sel, cur_owner);
                end
                check_eq("bus_valid", bif.bus_valid, |(bif.gnt & bif.req));
                if (bif.bus_valid && bif.bus_ready) cur_beats++;
            end else begin
                if (in_ten) begin
                    end_tenure(1'b0);
                    in_ten  = 1'b0;
                    gap_cnt = 1;
                end else if (gap_cnt < 1000) begin
                    gap_cnt++;
                end
            end
        end
    end

    // Inputs change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bif.req       = 16'd0;
        bif.bus_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
    endtask

    // Wait for every queued tenure to complete, then release all requests
    // while the arbiter sits in its turnaround cycle.
    task automatic drain(input int max_cycles);
        bit done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check_eq("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        bif.req = 16'd0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bif.req       = 16'd0;
        bif.bus_ready = 1'b1;
        #12;
        // Reset state
        check_eq("rst_sel", bif.sel, 4'd0);
        check_eq("rst_gnt", bif.gnt, 16'd0);
        check_eq("rst_valid", bif.bus_valid, 1'b0);
        check_eq("rst_busy", bif.arb_busy, 1'b0);
        do_reset();

        // Single requester: 4 beats, turnaround, regrant after a one-cycle gap.
        exp_ten(0, 4, -1);
        exp_ten(0, 4, 1);
        bif.req = 16'h0001;
        @(posedge clk);
        #1;
        check_eq("t1_gnt", bif.gnt, 16'h0001);
        check_eq("t1_sel", bif.sel, 4'd0);
        check_eq("t1_busy", bif.arb_busy, 1'b1);
        drain(100);

        // All requesting: full rotation with one-cycle gaps.
        do_reset();
        for (int k = 0; k <= 16; k++) begin
`ifdef ARB_PRIORITY_EN
            exp_ten(0, 4, (k == 0) ? -1 : 1);
`else
            exp_ten(k % 16, 4, (k == 0) ? -1 : 1);
`endif
        end
        bif.req = 16'hFFFF;
        drain(300);

        // Owner 5 drops its request after 2 beats while 9 waits.
        do_reset();
        exp_ten(5, 2, -1);
        exp_ten(9, 4, 1);
        bif.req = 16'h0220;
        repeat (3) @(posedge clk);
        #2;
        bif.req = 16'h0200;
        @(posedge clk);
        #1;
        check_eq("t3_turn_gnt", bif.gnt, 16'h0000);
        check_eq("t3_turn_busy", bif.arb_busy, 1'b1);
        @(posedge clk);
        #1;
        check_eq("t3_gnt9", bif.gnt, 16'h0200);
        check_eq("t3_sel9", bif.sel, 4'd9);
        drain(100);

        // Requester 3 stalled by bus_ready for 10 cycles: still exactly 4 beats.
        do_reset();
        exp_ten(3, 4, -1);
        exp_ten(3, 4, 1);
        bif.req = 16'h0008;
        step();
        step();
        bif.bus_ready = 1'b0;
        repeat (10) step();
        check_eq("t4_stall_gnt", bif.gnt, 16'h0008);
        check_eq("t4_stall_valid", bif.bus_valid, 1'b1);
        bif.bus_ready = 1'b1;
        drain(100);

        // Reset mid-tenure of 7; the restart search begins at requester 0.
        do_reset();
        exp_ten(7, -1, -1);
        exp_ten(0, 4, -1);
        bif.req = 16'h0080;
        step();
        check_eq("t5_gnt7", bif.gnt, 16'h0080);
        step();
        bif.req = 16'h0081;
        step();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_gnt", bif.gnt, 16'h0000);
        check_eq("t5_rst_sel", bif.sel, 4'd0);
        check_eq("t5_rst_busy", bif.arb_busy, 1'b0);
        check_eq("t5_rst_valid", bif.bus_valid, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_regnt", bif.gnt, 16'h0001);
        check_eq("t5_resel", bif.sel, 4'd0);
        drain(100);

        // Requesters 0 and 4 held: alternation, or 0 every time with priority.
        do_reset();
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_PRIORITY_EN
            exp_ten(0, 4, (k == 0) ? -1 : 1);
`else
            exp_ten((k % 2 == 0) ? 0 : 4, 4, (k == 0) ? -1 : 1);
`endif
        end
        bif.req = 16'h0011;
        drain(100);

        check_eq("sb_leftover", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
